// File: rtl/panel_scanner_pkg.sv
// Shared types and helpers for the HUB75 panel scanner.
// States, plane count, RGB565 field layout and address packing.
package panel_scanner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SETTLE,
        SHOW
    } scan_state_e;

    localparam int PLANES = 5;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 6;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Pack {half, row, col} into a pixel RAM address.
    function automatic logic [11:0] pix_addr(
        input logic       half,
        input logic [4:0] row,
        input logic [5:0] col
    );
        return {half, row, col};
    endfunction

    // Pick bit p of each 5-bit colour field; green drops its LSB.
    function automatic logic [2:0] plane_bits(
        input logic [15:0] d,
        input logic [2:0]  p
    );
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
        r = d[R_MSB:R_LSB] >> p;
        g = d[G_MSB:G_LSB] >> p;
        b = d[B_MSB:B_LSB] >> p;
        return {r[0], g[0], b[0]};
    endfunction

endpackage

// File: rtl/panel_scanner_bcm_timer.sv
// Loadable down-counter for the settle and display windows.
// o_done is high on the last cycle of a loaded window of N cycles.
module bcm_timer
    import panel_scanner_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load takes priority; otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/panel_scanner.sv
// Frame scanner: reads the pixel RAM and drives a 64x64 HUB75
// panel at 1/32 scan with 5-plane binary-code modulation.
module panel_scanner
    import panel_scanner_pkg::*;
#(
    parameter int COLS       = 64,
    parameter int HALF_ROWS  = 32,
    parameter int BASE_TICKS = 8,
    parameter int DEAD_TICKS = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    output logic [11:0] o_r_addr,
    output logic        o_r_enable,
    input  logic [15:0] i_r_data,
    output logic [2:0]  o_rgb_top,
    output logic [2:0]  o_rgb_bot,
    output logic [4:0]  o_row_addr,
    output logic        o_panel_clk,
    output logic        o_latch,
    output logic        o_oe_n,
    output logic        o_frame_done
);

    localparam int TW = $clog2((BASE_TICKS << (PLANES - 1)) + 1);
    localparam logic [5:0] COL_LAST   = 6'(COLS - 1);
    localparam logic [4:0] ROW_LAST   = 5'(HALF_ROWS - 1);
    localparam logic [2:0] PLANE_LAST = 3'(PLANES - 1);

    scan_state_e state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [1:0]  phase_q, phase_d;
    logic [4:0]  row_q, row_d;
    logic [2:0]  plane_q, plane_d;
    logic [4:0]  row_addr_q, row_addr_d;
    logic [2:0]  top_bits_q, top_bits_d;
    logic [2:0]  top_hold_q, top_hold_d;
    logic [2:0]  bot_hold_q, bot_hold_d;
    logic        frame_done_q, frame_done_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_done;

    bcm_timer #(
        .WIDTH (TW)
    ) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (tmr_load),
        .i_value (tmr_value),
        .o_done  (tmr_done)
    );

    // Next-state logic: column walk, plane/row advance, timer loads.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        phase_d      = phase_q;
        row_d        = row_q;
        plane_d      = plane_q;
        row_addr_d   = row_addr_q;
        top_bits_d   = top_bits_q;
        top_hold_d   = top_hold_q;
        bot_hold_d   = bot_hold_q;
        frame_done_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        unique case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = FETCH;
                    col_d   = '0;
                    phase_d = '0;
                end
            end
            FETCH: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd1) begin
                    top_bits_d = plane_bits(i_r_data, plane_q);
                end
                if (phase_q == 2'd2) begin
                    top_hold_d = top_bits_q;
                    bot_hold_d = plane_bits(i_r_data, plane_q);
                end
                if (phase_q == 2'd3) begin
                    col_d = col_q + 6'd1;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                row_addr_d = row_q;
                state_d    = SETTLE;
                tmr_load   = 1'b1;
                tmr_value  = TW'(DEAD_TICKS);
            end
            SETTLE: begin
                if (tmr_done) begin
                    state_d   = SHOW;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(BASE_TICKS) << plane_q;
                end
            end
            SHOW: begin
                if (tmr_done) begin
                    if (plane_q == PLANE_LAST) begin
                        plane_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + 5'd1;
                        end
                    end else begin
                        plane_d = plane_q + 3'd1;
                    end
                    col_d   = '0;
                    phase_d = '0;
                    state_d = i_enable ? FETCH : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            phase_q      <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            row_addr_q   <= '0;
            top_bits_q   <= '0;
            top_hold_q   <= '0;
            bot_hold_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            row_addr_q   <= row_addr_d;
            top_bits_q   <= top_bits_d;
            top_hold_q   <= top_hold_d;
            bot_hold_q   <= bot_hold_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Panel and RAM outputs decoded from the registered state.
    always_comb begin
        o_r_addr    = '0;
        o_r_enable  = 1'b0;
        o_panel_clk = 1'b0;
        o_latch     = 1'b0;
        o_oe_n      = 1'b1;
        o_rgb_top   = top_hold_q;
        o_rgb_bot   = bot_hold_q;
        unique case (state_q)
            FETCH: begin
                unique case (phase_q)
                    2'd0: begin
                        o_r_addr   = pix_addr(1'b0, row_q, col_q);
                        o_r_enable = 1'b1;
                    end
                    2'd1: begin
                        o_r_addr   = pix_addr(1'b1, row_q, col_q);
                        o_r_enable = 1'b1;
                    end
                    2'd2: begin
                        o_rgb_top = top_bits_q;
                        o_rgb_bot = plane_bits(i_r_data, plane_q);
                    end
                    default: begin
                        o_panel_clk = 1'b1;
                    end
                endcase
            end
            LATCH: begin
                o_latch = 1'b1;
            end
            SHOW: begin
                o_oe_n = 1'b0;
            end
            default: begin
                o_oe_n = 1'b1;
            end
        endcase
    end

    assign o_row_addr   = row_addr_q;
    assign o_frame_done = frame_done_q;

endmodule
